// File: rtl/pwm_gen_pkg.sv
// Shared types and constants for the UART-controlled PWM path.
// The command codes are also decoded by cmd_parser.
package pwm_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_DIV_W = 8;

    typedef enum logic [7:0] {
        CMD_DUTY   = 8'h44,  // "D"
        CMD_ENABLE = 8'h45,  // "E"
        CMD_FREQ   = 8'h46   // "F"
    } cmd_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits one tick every div+1 clocks while clr is low.
// clr holds the counter at zero so a restart always begins a fresh tick interval.
module pwm_prescaler
    import pwm_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc;
    logic             hit;

    assign hit  = (presc == div);
    assign tick = !clr && hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clr || hit) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator with shadowed duty/divider settings and a 2^CNT_W-tick period.
// Shadows reload only at a period boundary (or on enable), so periods are never truncated.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] duty_cycle,
    input  logic [DIV_W-1:0] freq_div,
    input  logic             enable_pwm,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             active
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pwm_cnt, cnt_nxt;
    logic [CNT_W-1:0] duty_sh, duty_nxt;
    logic [DIV_W-1:0] div_sh, div_nxt;
    logic             pwm_nxt;
    logic             ptick_nxt;
    logic             clr;
    logic             tick;

    // Prescaler only runs on edges that stay in RUN; leaving RUN clears it at that edge.
    assign clr    = (state != ST_RUN) || !enable_pwm;
    assign active = (state == ST_RUN);

    pwm_prescaler #(
        .DIV_W(DIV_W)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .div (div_sh),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = pwm_cnt;
        duty_nxt  = duty_sh;
        div_nxt   = div_sh;
        pwm_nxt   = 1'b0;
        ptick_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt  = '0;
                duty_nxt = duty_cycle;
                div_nxt  = freq_div;
                if (enable_pwm) begin
                    state_nxt = ST_RUN;
                    ptick_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_pwm) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // Compare uses the count before this edge, so pwm_out lags pwm_cnt by one clock.
                    pwm_nxt = (pwm_cnt < duty_sh);
                    if (tick) begin
                        cnt_nxt = pwm_cnt + 1'b1;
                        if (pwm_cnt == CNT_MAX) begin
                            duty_nxt  = duty_cycle;
                            div_nxt   = freq_div;
                            ptick_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt     <= '0;
            duty_sh     <= '0;
            div_sh      <= '0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            pwm_cnt     <= cnt_nxt;
            duty_sh     <= duty_nxt;
            div_sh      <= div_nxt;
            pwm_out     <= pwm_nxt;
            period_tick <= ptick_nxt;
        end
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Downstream stage of cmd_parser in the UART-controlled PWM path.
- Consumes the duty_cycle, freq_div and enable_pwm settings and produces a single PWM output.
- Period is 256 prescaled ticks. Duty and divider are double-buffered (shadowed) so that a setting change never produces a glitched or truncated period.

Parameters:
- CNT_W, 8, width of duty_cycle and of the PWM period counter. Period is 2^CNT_W ticks.
- DIV_W, 8, width of freq_div and of the prescaler counter.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  reset, asynchronous, active-low. All state clears while rst==0.
- duty_cycle  input  CNT_W  requested high-time in ticks per period, from cmd_parser.
- freq_div  input  DIV_W  prescaler divide value; tick every freq_div+1 clocks.
- enable_pwm  input  1  level enable, from cmd_parser.
- pwm_out  output  1  registered PWM waveform.
- period_tick  output  1  one-cycle pulse marking the start of each PWM period.
- active  output  1  high while the state machine is in RUN.

Behaviour:
Reset (rst==0):
- state=IDLE; presc=0; pwm_cnt=0; duty_sh=0; div_sh=0.
- pwm_out=0, period_tick=0, active=0.

State machine (states IDLE and RUN, one-hot-free 1-bit encoding):
- IDLE:
  - presc=0 and pwm_cnt=0.
  - duty_sh<=duty_cycle and div_sh<=freq_div on every edge.
  - pwm_out=0.
  - When enable_pwm==1 is sampled: go to RUN, load the shadows from the inputs, and pulse period_tick at that edge.
- RUN, per edge:
  - If enable_pwm==0 is sampled: go to IDLE; presc, pwm_cnt and pwm_out clear at that same edge. There is no period completion.
  - Otherwise the prescaler runs: if presc==div_sh then presc<=0 and tick=1, else presc<=presc+1.
  - On tick, pwm_cnt<=pwm_cnt+1, with natural wrap 2^CNT_W-1 -> 0.
  - On tick with pwm_cnt==2^CNT_W-1 (period boundary): duty_sh<=duty_cycle, div_sh<=freq_div, period_tick<=1.
  - pwm_out<=(pwm_cnt<duty_sh), registered. It reflects the count present before the edge, so the output lags the count by one clock.

Timing:
- Period length is 2^CNT_W*(div_sh+1) clocks.
- High time is duty_sh*(div_sh+1) clocks.
- Latency: enable sampled at edge k -> active=1 after edge k -> pwm_out first high after edge k+1 (if duty_sh>0).

Boundaries:
- duty=0: pwm_out constantly 0 in RUN.
- duty=255: high 255 of 256 ticks. 100% is not reachable; this is by design.
- freq_div=0: one tick per clock. freq_div=255: tick every 256 clocks.
- Input changes mid-period are ignored until the period boundary. There is no prescaler overshoot, because the compare uses div_sh.
- enable_pwm toggling within one cycle: only the sampled level matters. Re-enable restarts at count 0 with fresh shadows.
- Reset mid-period: immediate clear, asynchronous.
- Counters are unsigned, CNT_W/DIV_W wide, and wrap naturally. No saturation.

Decomposition:
- Shared include uart_pwm_defs.vh holds:
  - state encodings ST_IDLE/ST_RUN;
  - default widths DUTY_W=8, DIV_W=8;
  - command byte constants "D","F","E", also used by cmd_parser.
- One natural sub-module: pwm_prescaler.
  - Inputs: clk, rst, clr, div.
  - Output: tick.
  - Contains presc and the compare.
- pwm_gen itself owns the FSM, the shadows, pwm_cnt and the output registers.

Test Plan:
1. Reset then idle: rst low 20 ns, enable_pwm=0 for 1000 clocks -> pwm_out=0, active=0, period_tick never pulses.
2. Basic run, duty_cycle=128, freq_div=0, enable_pwm=1:
   - period_tick every 256 clocks;
   - pwm_out high exactly 128 clocks per period;
   - first rising edge of pwm_out one clock after active rises.
3. Divider, duty_cycle=128, freq_div=10:
   - period_tick spacing 2816 clocks;
   - pwm_out high 1408 clocks per period.
4. Shadowing: running duty=64, freq_div=0; change duty_cycle to 200 at clock 100 of a period:
   - current period stays high 64 clocks;
   - next period (after period_tick) high 200 clocks.
5. Extremes: duty=0 -> pwm_out never high over 3 periods; duty=255, freq_div=0 -> high 255, low 1 per period.
6. Disable and async reset mid-period:
   - enable_pwm 1->0 at clock 50 -> pwm_out=0, active=0 at the next edge;
   - re-enable -> period_tick pulses and the count restarts from 0;
   - separately, rst low mid-high-phase -> pwm_out drops without waiting for clk.
